// File: rtl/ps2_kb_device_tx_if.sv
// Queue-side interface of the PS/2 device transmitter: byte load strobe plus status.
interface ps2_kb_device_tx_if;
  logic [7:0] data;
  logic       dataload;
  logic       fifo_full;
  logic       busy;
  logic       sent;
  logic       aborted;

  modport master (
    output data, dataload,
    input  fifo_full, busy, sent, aborted
  );

  modport slave (
    input  data, dataload,
    output fifo_full, busy, sent, aborted
  );
endinterface

// File: rtl/ps2_kb_device_tx.sv
// PS/2 device-side transmitter: queues bytes in a small FIFO and sends each as an
// 11-bit frame (start, 8 data LSB first, odd parity, stop), driving clock and data
// open-collector style. A host clock inhibit during a high phase aborts the frame,
// which is retried from the start once the bus has been idle long enough.
module ps2_kb_device_tx #(
  parameter int unsigned HALF_BIT_CYCLES = 1120,
  parameter int unsigned FIFO_LOG2       = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  ps2_kb_device_tx_if.slave    q,
  input  logic                 ps2clk_i,
  input  logic                 ps2data_i,
  output logic                 ps2clk_o,
  output logic                 ps2data_o
);

  localparam int unsigned DEPTH = 1 << FIFO_LOG2;
  localparam int unsigned PW    = FIFO_LOG2 + 1;
  localparam int unsigned CW    = $clog2(2 * HALF_BIT_CYCLES + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT_CYCLES - 1);
  localparam logic [CW-1:0] IDLE_NEED = CW'(2 * HALF_BIT_CYCLES);
  // The released clock needs a few cycles to propagate through the synchroniser
  // before a low reading can be trusted as a host inhibit.
  localparam logic [CW-1:0] INH_START = CW'(3);
  localparam logic [3:0]    LAST_IDX  = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BUS,
    S_BIT_HIGH,
    S_BIT_LOW,
    S_GAP
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [3:0]      idx, idx_nx;

  logic [1:0]      clk_sync, data_sync;
  logic            s_clk, s_data;

  logic [7:0]      mem [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0]   count, count_nx;
  logic            full_q, empty, push, pop;

  logic            pop_fsm, sent_fsm, abort_fsm;
  logic            clk_drv_nx, data_drv_nx;
  logic            clk_drv_q, data_drv_q;
  logic [7:0]      head;
  logic [10:0]     frame;

  // Two-flop synchronisers for the sensed bus lines (idle level is high).
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2clk_i};
      data_sync <= {data_sync[0], ps2data_i};
    end
  end

  assign s_clk  = clk_sync[1];
  assign s_data = data_sync[1];

  // FIFO: a write to a full FIFO is accepted only when the head is popped the same cycle.
  assign empty = (count == '0);
  assign pop   = pop_fsm && !rst;
  assign push  = q.dataload && (!full_q || pop);

  // Next occupancy, used to register the full flag.
  always_comb begin
    count_nx = count;
    if (push && !pop)      count_nx = count + 1'b1;
    else if (pop && !push) count_nx = count - 1'b1;
  end

  // FIFO pointers, occupancy and registered full flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count  <= count_nx;
      full_q <= (count_nx == PW'(DEPTH));
    end
  end

  // FIFO storage; contents need no reset since occupancy governs validity.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= q.data;
  end

  assign head  = mem[rd_ptr];
  assign frame = {1'b1, ~^head, head, 1'b0};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  end

  // FSM next-state, phase counter and bit index.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    idx_nx    = idx;
    pop_fsm   = 1'b0;
    sent_fsm  = 1'b0;
    abort_fsm = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (!empty) state_nx = S_WAIT_BUS;
      end
      S_WAIT_BUS: begin
        if (!(s_clk && s_data)) begin
          cnt_nx = '0;
        end else if (cnt == IDLE_NEED) begin
          state_nx = S_BIT_HIGH;
          cnt_nx   = '0;
          idx_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_BIT_HIGH: begin
        if (cnt >= INH_START && !s_clk) begin
          abort_fsm = 1'b1;
          state_nx  = S_WAIT_BUS;
          cnt_nx    = '0;
        end else if (cnt == HALF_LAST) begin
          state_nx = S_BIT_LOW;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_BIT_LOW: begin
        if (cnt == HALF_LAST) begin
          cnt_nx = '0;
          if (idx == LAST_IDX) begin
            state_nx = S_GAP;
          end else begin
            idx_nx   = idx + 4'd1;
            state_nx = S_BIT_HIGH;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt == HALF_LAST) begin
          pop_fsm  = 1'b1;
          sent_fsm = 1'b1;
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
        idx_nx   = '0;
      end
    endcase
  end

  // Line drives derived from the next state so the pins come straight from flops.
  always_comb begin
    clk_drv_nx  = (state_nx != S_BIT_LOW);
    data_drv_nx = 1'b1;
    if (state_nx == S_BIT_HIGH || state_nx == S_BIT_LOW) data_drv_nx = frame[idx_nx];
  end

  // Registered open-collector drives; released on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_drv_q  <= 1'b1;
      data_drv_q <= 1'b1;
    end else begin
      clk_drv_q  <= clk_drv_nx;
      data_drv_q <= data_drv_nx;
    end
  end

  assign ps2clk_o    = clk_drv_q;
  assign ps2data_o   = data_drv_q;
  assign q.fifo_full = full_q;
  assign q.busy      = (state != S_IDLE);
  assign q.sent      = sent_fsm && !rst;
  assign q.aborted   = abort_fsm && !rst;

endmodule

// File: tb/tb_ps2_kb_device_tx.sv
// Bench for ps2_kb_device_tx: open-collector bus model, host that samples data on
// falling edges of the device clock, and a scoreboard of queued bytes.
module tb_ps2_kb_device_tx;
  localparam int unsigned H = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic host_clk = 1'b1;
  logic host_data = 1'b1;
  logic ps2clk_o, ps2data_o;
  logic clk_line, data_line;

  assign clk_line  = ps2clk_o & host_clk;
  assign data_line = ps2data_o & host_data;

  ps2_kb_device_tx_if kbq ();

  ps2_kb_device_tx #(.HALF_BIT_CYCLES(H), .FIFO_LOG2(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .q         (kbq),
    .ps2clk_i  (clk_line),
    .ps2data_i (data_line),
    .ps2clk_o  (ps2clk_o),
    .ps2data_o (ps2data_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Host model and scoreboard.
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_b;
  logic [10:0] shreg = '0;
  logic [10:0] last_frame = '0;
  int n_sent = 0, n_abort = 0, n_fall = 0, n_frames = 0, cyc = 0;
  int nbits = 0, lowcnt = 0, t_stop_rise = 0, last_gap = 0;
  logic prev_clk_o = 1'b1;
  logic prev_data = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      nbits  = 0;
      lowcnt = 0;
    end else begin
      if (kbq.aborted) begin
        n_abort++;
        nbits = 0;
      end
      if (kbq.sent) n_sent++;
      if (nbits == 0 && ps2clk_o && prev_data && !data_line) last_gap = cyc - t_stop_rise;
      if (prev_clk_o && !ps2clk_o) begin
        shreg[nbits] = data_line;
        nbits++;
        n_fall++;
        if (nbits == 11) begin
          nbits = 0;
          last_frame = shreg;
          n_frames++;
          chk("start_bit", shreg[0], 0);
          chk("stop_bit", shreg[10], 1);
          chk("odd_parity", shreg[9], ~^shreg[8:1]);
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", shreg[8:1], 32'hFFFF_FFFF);
          end else begin
            exp_b = exp_q.pop_front();
            chk("frame_data", shreg[8:1], exp_b);
          end
        end
      end
      if (!ps2clk_o) begin
        lowcnt++;
      end else if (lowcnt != 0) begin
        chk("low_phase_len", lowcnt, H);
        lowcnt = 0;
        if (nbits == 0) t_stop_rise = cyc;
      end
    end
    prev_clk_o = ps2clk_o;
    prev_data  = data_line;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [7:0] b, input bit accept);
    kbq.data     = b;
    kbq.dataload = 1'b1;
    if (accept) exp_q.push_back(b);
    step();
    kbq.dataload = 1'b0;
  endtask

  task automatic wait_sent(input int target, input int budget, input string nm);
    int k;
    k = 0;
    while (n_sent < target && k < budget) begin
      step();
      k++;
    end
    chk(nm, n_sent, target);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;

  vec_t vt[4];

  initial begin
    int s0, a0, f0, f1, fr0, k;
    vt[0] = '{8'h1C, 11'h438};
    vt[1] = '{8'h00, 11'h600};
    vt[2] = '{8'hFF, 11'h7FE};
    vt[3] = '{8'hA5, 11'h74A};

    kbq.data     = '0;
    kbq.dataload = 1'b0;
    step(3);
    chk("rst_clk_o", ps2clk_o, 1);
    chk("rst_data_o", ps2data_o, 1);
    chk("rst_busy", kbq.busy, 0);
    chk("rst_sent", kbq.sent, 0);
    chk("rst_aborted", kbq.aborted, 0);
    chk("rst_full", kbq.fifo_full, 0);
    rst = 1'b0;
    step(2);

    // Single frames from the vector table.
    for (int i = 0; i < 4; i++) begin
      s0 = n_sent;
      f0 = n_fall;
      load(vt[i].data, 1'b1);
      wait_sent(s0 + 1, 1000, "tbl_sent");
      step();
      chk("tbl_busy_low", kbq.busy, 0);
      chk("tbl_frame_bits", last_frame, vt[i].frame);
      chk("tbl_falls", n_fall - f0, 11);
    end

    // Back-to-back 0x00 / 0xFF with minimum inter-frame gap.
    s0 = n_sent;
    load(8'h00, 1'b1);
    load(8'hFF, 1'b1);
    wait_sent(s0 + 2, 1500, "b2b_sent");
    chk("b2b_gap_ge_26", (last_gap >= 26), 1);

    // Host inhibit during the high phase of bit index 5.
    s0 = n_sent; a0 = n_abort; f0 = n_fall; fr0 = n_frames;
    load(8'h1C, 1'b1);
    k = 0;
    while ((n_fall - f0) < 5 && k < 1000) begin step(); k++; end
    chk("inh_reach_idx5", n_fall - f0, 5);
    k = 0;
    while (!ps2clk_o && k < 20) begin step(); k++; end
    step();
    host_clk = 1'b0;
    step(3);
    chk("inh_abort_pulse", n_abort - a0, 1);
    chk("inh_clk_released", ps2clk_o, 1);
    chk("inh_data_released", ps2data_o, 1);
    f1 = n_fall;
    step(97);
    chk("inh_no_drive_held", n_fall - f1, 0);
    host_clk = 1'b1;
    wait_sent(s0 + 1, 1000, "inh_resent");
    step(50);
    chk("inh_one_sent", n_sent - s0, 1);
    chk("inh_one_abort", n_abort - a0, 1);
    chk("inh_one_frame", n_frames - fr0, 1);

    // FIFO full while the host holds data low.
    s0 = n_sent;
    host_data = 1'b0;
    step(2);
    for (int i = 1; i <= 9; i++) begin
      load(8'(i), (i <= 8));
      if (i == 7) chk("full_after7", kbq.fifo_full, 0);
      if (i == 8) chk("full_after8", kbq.fifo_full, 1);
    end
    chk("full_after9", kbq.fifo_full, 1);
    f0 = n_fall;
    step(200);
    chk("rts_no_start", n_fall - f0, 0);
    chk("rts_data_released", ps2data_o, 1);
    chk("rts_busy", kbq.busy, 1);
    host_data = 1'b1;
    wait_sent(s0 + 8, 3000, "full_eight_sent");
    step();
    chk("full_drained_busy", kbq.busy, 0);
    chk("full_sb_empty", exp_q.size(), 0);

    // Reset during the low phase of bit index 3.
    s0 = n_sent; a0 = n_abort;
    for (int i = 0; i < 8; i++) load(8'h30 + 8'(i), 1'b1);
    chk("rst_pre_full", kbq.fifo_full, 1);
    f0 = n_fall;
    k = 0;
    while ((n_fall - f0) < 4 && k < 1000) begin step(); k++; end
    chk("rst_reach_idx3", n_fall - f0, 4);
    step(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_clk_o", ps2clk_o, 1);
    chk("mid_rst_data_o", ps2data_o, 1);
    chk("mid_rst_busy", kbq.busy, 0);
    chk("mid_rst_full", kbq.fifo_full, 0);
    exp_q.delete();
    f1 = n_fall;
    step(600);
    chk("post_rst_no_frames", n_fall - f1, 0);
    chk("post_rst_no_sent", n_sent - s0, 0);
    chk("post_rst_no_abort", n_abort - a0, 0);

    // Write on the final GAP cycle while the FIFO is full.
    s0 = n_sent; fr0 = n_frames;
    for (int i = 0; i < 8; i++) load(8'h40 + 8'(i), 1'b1);
    chk("t6_full", kbq.fifo_full, 1);
    k = 0;
    while (!kbq.sent && k < 1000) begin step(); k++; end
    chk("t6_gap_final_seen", kbq.sent, 1);
    kbq.data     = 8'h48;
    kbq.dataload = 1'b1;
    exp_q.push_back(8'h48);
    step();
    kbq.dataload = 1'b0;
    chk("t6_full_stays", kbq.fifo_full, 1);
    wait_sent(s0 + 9, 3000, "t6_nine_sent");
    step();
    chk("t6_nine_frames", n_frames - fr0, 9);
    chk("t6_busy_low", kbq.busy, 0);

    chk("sb_empty_end", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout got=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_kb_device_tx.md
Name: ps2_kb_device_tx

Overview:
- PS/2 device-side transmitter. Emulates the keyboard end of the PS/2 link: drives clock and data to send queued scancode bytes to a PS/2 host.
- Complements the host-side receive/write logic in the keyboard subsystem. Used for the internal keyboard-emulation path and loopback verification of the host port.
- Bytes are queued by the CPU or internal logic through a small FIFO and sent as standard 11-bit frames.
- Honours host inhibit by aborting and retransmitting the frame.

Parameters:
- HALF_BIT_CYCLES, 1120, clk cycles per PS/2 clock half-period (28 MHz -> ~12.5 kHz).
- FIFO_LOG2, 3, log2 of FIFO depth (8 entries).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- data  in  8  byte to queue.
- dataload  in  1  one-cycle write strobe for data.
- fifo_full  out  1  FIFO holds 2^FIFO_LOG2 entries.
- ps2clk_i  in  1  sensed PS/2 clock line (asynchronous).
- ps2data_i  in  1  sensed PS/2 data line (asynchronous).
- ps2clk_o  out  1  clock drive, open-collector: 0 = pull low, 1 = release.
- ps2data_o  out  1  data drive, open-collector: 0 = pull low, 1 = release.
- busy  out  1  frame in progress.
- sent  out  1  one-cycle pulse per byte completed.
- aborted  out  1  one-cycle pulse per frame aborted by host inhibit.

Behaviour:
- Reset values:
  - ps2clk_o=1, ps2data_o=1.
  - busy=0, sent=0, aborted=0, fifo_full=0.
  - FIFO emptied; FSM in IDLE.
- Reset mid-frame releases both lines on the next cycle. No sent or aborted pulse is generated.
- Input synchronisation: ps2clk_i and ps2data_i pass through 2-flop synchronisers (s_clk, s_data). All decisions use the synchronised values.
- FIFO:
  - Write when dataload=1 and not full. A write while full is dropped silently.
  - Pop only at frame completion. Simultaneous write and pop are both honoured.
  - Pointers wrap modulo depth.
  - fifo_full is registered and updates the cycle after the write or pop.
- Frame format: start 0, data bits 0..7 LSB first, odd parity (bit = ~^data), stop 1.
- FSM states:
  - IDLE: lines released, busy=0. If FIFO is non-empty, go to WAIT_BUS.
  - WAIT_BUS: busy=1, lines released.
    - Counts consecutive cycles with s_clk=1 and s_data=1; any other value resets the count.
    - After 2*HALF_BIT_CYCLES such cycles, go to BIT_HIGH with bit index 0.
    - If s_data=0 (host request-to-send), the device never starts. Receiving host commands is out of scope.
  - BIT_HIGH: ps2data_o = frame bit[index], ps2clk_o=1, for HALF_BIT_CYCLES cycles.
    - From cycle 4 of the phase onward, s_clk=0 means host inhibit, which triggers an abort.
    - Abort: release both lines next cycle, pulse aborted, keep the FIFO head, go to WAIT_BUS.
  - BIT_LOW: ps2clk_o=0, data held, for HALF_BIT_CYCLES cycles.
    - If index<10: increment index and go to BIT_HIGH.
    - If index=10: go to GAP.
    - No inhibit check during BIT_LOW.
  - GAP: lines released for HALF_BIT_CYCLES cycles. On the final cycle, pop the FIFO and pulse sent, then go to IDLE.
- Abort window: inhibit is checked only in the BIT_HIGH phases of indices 0..10. Once the 11th falling clock edge (stop bit) has been driven, the byte counts as delivered.
- Back-to-back bytes: each frame passes through IDLE and WAIT_BUS again. Minimum inter-frame gap is 3*HALF_BIT_CYCLES plus 2 cycles.
- Timing: frame length is 22*HALF_BIT_CYCLES cycles from the first BIT_HIGH cycle to the end of the last BIT_LOW. Counter width is sized for HALF_BIT_CYCLES*2.

Test Plan:
(Bench uses HALF_BIT_CYCLES=8, and a host model that samples data on each falling edge of ps2clk_o.)
1. Single byte: dataload with data=0x1C, bus idle.
   - Host receives bits 0,0,0,1,1,1,0,0,0,0(parity),1.
   - 11 falling edges, each low phase 8 cycles.
   - One sent pulse; busy low afterwards.
2. Parity edge: send 0x00 then 0xFF.
   - Parity bits are 1 and 1.
   - Two sent pulses, frames separated by ≥26 cycles.
3. Inhibit mid-frame: queue 0x1C; host pulls clock low during BIT_HIGH of index 5 for 100 cycles, then releases.
   - aborted pulses once; ps2clk_o and ps2data_o read 1 within 3 cycles of the pull.
   - After release, the full 0x1C frame is retransmitted.
   - Exactly one sent pulse.
4. FIFO full: 9 dataload strobes (0x01..0x09) in consecutive cycles while the host holds data low (RTS).
   - fifo_full=1 after the 8th write; 0x09 is dropped; no start bit while data is held low.
   - After release, frames 0x01..0x08 go out in order, with 8 sent pulses.
5. Reset mid-frame: assert rst for 1 cycle during BIT_LOW of index 3.
   - Next cycle: ps2clk_o=1, ps2data_o=1, busy=0, fifo_full=0.
   - No sent or aborted pulse; no further frames.
6. Simultaneous write and pop: with 8 entries queued, assert dataload on the GAP final cycle.
   - The write is accepted and fifo_full stays 1.
   - 9 bytes are delivered in total.
